uart_rx: RTL and testbench
==========================

// Module: uart_rx
//
// PURPOSE
//   8N1 UART receiver for the USB-UART receive pin on the CMOD A7 dev board.
//   Synchronises the asynchronous line, samples each bit at mid-bit and
//   presents each received byte through a one-entry valid/ready buffer.
//   Reports framing errors and overruns as single-cycle pulses.
//
// PARAMETERS
//   CLKS_PER_BIT  104  clk cycles per UART bit (12 MHz / 115200 baud); must be >= 4
//
// PORTS
//   clk        in   1  system clock; all logic on posedge
//   rst        in   1  asynchronous, active-high reset
//   rxd        in   1  raw UART line (idle high), asynchronous to clk
//   rx_data    out  8  received byte; stable while rx_valid=1
//   rx_valid   out  1  rx_data holds an unconsumed byte
//   rx_ready   in   1  consumer accepts rx_data on a posedge where rx_valid=1
//   frame_err  out  1  1-cycle pulse: stop bit sampled low, byte discarded
//   overrun    out  1  1-cycle pulse: byte completed while buffer full, new byte dropped
//
// BEHAVIOUR
//   Reset: rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, FSM=IDLE,
//     synchroniser flops=1, bit counter and cycle counter=0. Reset mid-frame
//     abandons the frame and clears the buffer.
//   Input: rxd passes a 2-flop synchroniser (rxs). All decisions use rxs.
//   FSM:
//     IDLE:  rxs=0 -> START, cycle counter cleared.
//     START: after CLKS_PER_BIT/2 (integer division) cycles, sample rxs;
//            1 -> IDLE (glitch, no output); 0 -> DATA, bit index=0.
//     DATA:  every CLKS_PER_BIT cycles sample rxs into shift reg, LSB first;
//            after bit 7 -> STOP.
//     STOP:  after CLKS_PER_BIT cycles sample rxs;
//            1 -> deliver byte, -> IDLE;
//            0 -> frame_err pulse, byte discarded, -> BREAK.
//     BREAK: wait for rxs=1, then -> IDLE (no false start on held-low line).
//   Sample timing: start edge seen in rxs at cycle T; start sampled at
//     T+CLKS_PER_BIT/2; data bit i at T+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT;
//     stop at T+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
//   Delivery (on the stop-sample cycle):
//     buffer empty, or rx_valid=1 and rx_ready=1 same cycle -> load rx_data,
//       rx_valid=1 from next cycle (1-cycle latency after stop sample).
//     rx_valid=1 and rx_ready=0 -> overrun pulse next cycle; rx_data/rx_valid
//       unchanged (old byte kept).
//   Handshake: rx_valid=1 and rx_ready=1 on a posedge clears rx_valid unless a
//     new byte loads in that same cycle (then rx_valid stays 1 with new data).
//     rx_ready with rx_valid=0 has no effect. rx_data never changes while
//     rx_valid=1 except by that simultaneous accept+load.
//   Pulses: frame_err and overrun are registered, high exactly one cycle, and
//     never high together (distinct stop-sample outcomes).
//   Next frame: start edge is accepted from the cycle after returning to IDLE,
//     so back-to-back frames with one stop bit are received without loss.
//
// TESTING
//   1. Send 0x55 then 0xA3 at 104 clk/bit, rx_ready=1 -> rx_valid 1-cycle
//      pulses carrying 0x55 then 0xA3; frame_err=overrun=0 throughout.
//   2. Drive rxd low for 30 cycles then high -> FSM returns to IDLE, no
//      rx_valid, no frame_err; following 0x3C received correctly.
//   3. Send 0x81 with stop bit low, hold rxd low 500 cycles, release, send
//      0x42 -> one frame_err pulse, no rx_valid for 0x81, 0x42 delivered.
//   4. rx_ready=0, send 0x11 then 0x22 -> rx_valid=1 with 0x11, one overrun
//      pulse at 0x22 stop sample, rx_data stays 0x11; raise rx_ready -> valid drops.
//   5. Assert rst during data bit 4 of 0xF0, release, send 0x0F -> all outputs
//      at reset values during rst, only 0x0F delivered afterwards.
//   6. rx_ready=0, buffer holds 0x12; raise rx_ready exactly on 0x34's
//      stop-sample cycle -> rx_valid stays 1, rx_data=0x34, no overrun.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-entry valid/ready
// output buffer, single-cycle framing-error and overrun pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, rxs_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            fe_q, fe_d;
  logic            ov_q, ov_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxs_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A start bit that is high again at mid-bit is treated as a glitch.
          state_d = rxs_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rxs_q) begin
            state_d = StIdle;
            // A same-cycle accept frees the buffer for the new byte.
            if (!valid_q || rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
          end else begin
            fe_d    = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rxs_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: byte delivery, glitch rejection, framing error and break,
// overrun, reset mid-frame and accept-with-load on the stop-sample cycle.
module tb_uart_rx;

  localparam int unsigned Cpb = 104;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;

  // Observed-event tallies, kept by the negedge monitor.
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         vcyc = 0;
  logic       pv = 1'b0;
  logic       pacc = 1'b0;
  logic [7:0] got[$];

  uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // A new byte is visible when valid rises or when the previous cycle accepted.
  always @(negedge clk) begin
    if (!rst) begin
      fe_cnt <= fe_cnt + int'(frame_err);
      ov_cnt <= ov_cnt + int'(overrun);
      vcyc   <= vcyc + int'(rx_valid);
      if (rx_valid && (!pv || pacc)) got.push_back(rx_data);
    end
    pv   <= rx_valid;
    pacc <= rx_valid && rx_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; a low stop bit is left on the line when the task returns.
  task automatic send(input logic [7:0] b, input logic stop);
    tick();
    rxd = 1'b0;
    repeat (Cpb) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (Cpb) tick();
    end
    rxd = stop;
    repeat (Cpb) tick();
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_fe", 32'(frame_err), 32'd0);
    chk("rst_ov", 32'(overrun), 32'd0);
    tick();
    rst = 1'b0;
    repeat (5) tick();

    // 1: two back-to-back bytes, consumer always ready
    send(8'h55, 1'b1);
    send(8'hA3, 1'b1);
    repeat (5) tick();
    chk("t1_nbytes", 32'(got.size()), 32'd2);
    chk("t1_byte0", 32'(got[0]), 32'h55);
    chk("t1_byte1", 32'(got[1]), 32'hA3);
    chk("t1_vcyc", 32'(vcyc), 32'd2);
    chk("t1_fe", 32'(fe_cnt), 32'd0);
    chk("t1_ov", 32'(ov_cnt), 32'd0);

    // 2: short low glitch is rejected, next byte still received
    rxd = 1'b0;
    repeat (30) tick();
    rxd = 1'b1;
    repeat (100) tick();
    chk("t2_glitch_nbytes", 32'(got.size()), 32'd2);
    chk("t2_glitch_fe", 32'(fe_cnt), 32'd0);
    send(8'h3C, 1'b1);
    repeat (5) tick();
    chk("t2_nbytes", 32'(got.size()), 32'd3);
    chk("t2_byte", 32'(got[2]), 32'h3C);

    // 3: framing error, line held low, then recovery
    send(8'h81, 1'b0);
    repeat (500) tick();
    chk("t3_fe_once", 32'(fe_cnt), 32'd1);
    chk("t3_no_byte", 32'(got.size()), 32'd3);
    rxd = 1'b1;
    repeat (10) tick();
    send(8'h42, 1'b1);
    repeat (5) tick();
    chk("t3_nbytes", 32'(got.size()), 32'd4);
    chk("t3_byte", 32'(got[3]), 32'h42);
    chk("t3_fe_final", 32'(fe_cnt), 32'd1);
    chk("t3_ov", 32'(ov_cnt), 32'd0);

    // 4: overrun with consumer stalled
    rx_ready = 1'b0;
    send(8'h11, 1'b1);
    repeat (5) tick();
    chk("t4_valid", 32'(rx_valid), 32'd1);
    chk("t4_data", 32'(rx_data), 32'h11);
    send(8'h22, 1'b1);
    repeat (5) tick();
    chk("t4_ov", 32'(ov_cnt), 32'd1);
    chk("t4_fe", 32'(fe_cnt), 32'd1);
    chk("t4_data_kept", 32'(rx_data), 32'h11);
    chk("t4_valid_kept", 32'(rx_valid), 32'd1);
    chk("t4_nbytes", 32'(got.size()), 32'd5);
    chk("t4_byte", 32'(got[4]), 32'h11);
    rx_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t4_valid_drop", 32'(rx_valid), 32'd0);

    // 5: reset during data bit 4 of 0xF0
    fork
      send(8'hF0, 1'b1);
      begin
        repeat (571) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_valid", 32'(rx_valid), 32'd0);
        chk("t5_rst_data", 32'(rx_data), 32'h00);
        chk("t5_rst_fe", 32'(frame_err), 32'd0);
        chk("t5_rst_ov", 32'(overrun), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
      end
    join
    repeat (20) tick();
    chk("t5_no_partial", 32'(got.size()), 32'd5);
    send(8'h0F, 1'b1);
    repeat (5) tick();
    chk("t5_nbytes", 32'(got.size()), 32'd6);
    chk("t5_byte", 32'(got[5]), 32'h0F);
    chk("t5_fe", 32'(fe_cnt), 32'd1);
    chk("t5_ov", 32'(ov_cnt), 32'd1);

    // 6: accept and load on the same stop-sample cycle
    rx_ready = 1'b0;
    send(8'h12, 1'b1);
    repeat (5) tick();
    chk("t6_hold_data", 32'(rx_data), 32'h12);
    fork
      send(8'h34, 1'b1);
      begin
        // Stop sample lands on the 992nd posedge after the fork.
        repeat (991) tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
      end
    join
    repeat (5) tick();
    chk("t6_valid", 32'(rx_valid), 32'd1);
    chk("t6_data", 32'(rx_data), 32'h34);
    chk("t6_ov", 32'(ov_cnt), 32'd1);
    chk("t6_nbytes", 32'(got.size()), 32'd8);
    chk("t6_byte0", 32'(got[6]), 32'h12);
    chk("t6_byte1", 32'(got[7]), 32'h34);
    rx_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_valid_drop", 32'(rx_valid), 32'd0);
    chk("t6_fe", 32'(fe_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
